// File: rtl/alu_negator.sv
// rtl/alu_negator.sv - registered two's-complement negation unit with overflow and zero flags
//
// Purpose:
//   Computes r = -a (invert then increment, carry-out dropped) and registers
//   the result one cycle after in_valid. The most-negative operand either
//   wraps to itself or clamps to +MAX depending on SATURATE; ovf flags it
//   in both cases. zero reflects the registered r.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand a is valid this cycle
//   a          in   L  signed operand
//   out_valid  out  1  r/ovf/zero carry a new result this cycle
//   r          out  L  signed result, -a
//   ovf        out  1  operand was the most-negative value
//   zero       out  1  r == 0

module alu_negator #(
  parameter int unsigned L        = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [L-1:0] a,
  output logic         out_valid,
  output logic [L-1:0] r,
  output logic         ovf,
  output logic         zero
);

  localparam logic [L-1:0] MIN_VAL = {1'b1, {(L-1){1'b0}}};
  localparam logic [L-1:0] MAX_VAL = {1'b0, {(L-1){1'b1}}};
  localparam logic [L-1:0] ONE     = {{(L-1){1'b0}}, 1'b1};

  logic [L-1:0] neg;
  logic         is_min;

  logic         out_valid_d, out_valid_q;
  logic [L-1:0] r_d, r_q;
  logic         ovf_d, ovf_q;
  logic         zero_d, zero_q;

  always_comb begin
    neg    = ~a + ONE;
    is_min = (a == MIN_VAL);

    // r/ovf/zero hold their last values when no operand arrives
    out_valid_d = in_valid;
    r_d         = r_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    if (in_valid) begin
      // neg of MIN is MIN itself, so the wrap case needs no special path
      r_d    = (is_min && SATURATE) ? MAX_VAL : neg;
      ovf_d  = is_min;
      zero_d = (r_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_negator.sv
// tb/tb_alu_negator.sv - directed-vector bench for alu_negator (L=4 wrap, L=4 saturate, L=16 sweep)

module tb_alu_negator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  a4 = '0;
  logic [15:0] a16 = '0;

  logic        ov_w, ovf_w, zero_w;
  logic [3:0]  r_w;
  logic        ov_s, ovf_s, zero_s;
  logic [3:0]  r_s;
  logic        ov_x, ovf_x, zero_x;
  logic [15:0] r_x;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_negator #(.L(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4),
    .out_valid(ov_w), .r(r_w), .ovf(ovf_w), .zero(zero_w)
  );

  alu_negator #(.L(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4),
    .out_valid(ov_s), .r(r_s), .ovf(ovf_s), .zero(zero_s)
  );

  alu_negator #(.L(16), .SATURATE(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16),
    .out_valid(ov_x), .r(r_x), .ovf(ovf_x), .zero(zero_x)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive one operand, then sample 1 time unit after the capturing edge
  task automatic step(input logic v, input logic [3:0] val);
    in_valid = v;
    a4       = val;
    @(posedge clk);
    #1;
  endtask

  // hand-computed L=4 vectors: a, r(wrap), r(sat), ovf, zero
  typedef struct {
    logic [3:0] a;
    logic [3:0] rw;
    logic [3:0] rs;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[7] = '{
    '{4'hF, 4'h1, 4'h1, 1'b0, 1'b0},  // -1 -> 1
    '{4'h7, 4'h9, 4'h9, 1'b0, 1'b0},  //  7 -> -7
    '{4'h5, 4'hB, 4'hB, 1'b0, 1'b0},  //  5 -> -5
    '{4'h8, 4'h8, 4'h7, 1'b1, 1'b0},  // -8 -> -8 wrap / 7 sat
    '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1},  //  0 -> 0
    '{4'h1, 4'hF, 4'hF, 1'b0, 1'b0},  //  1 -> -1
    '{4'h3, 4'hD, 4'hD, 1'b0, 1'b0}   //  3 -> -3
  };

  initial begin
    // held in reset: outputs stay 0 even with valid operands and edges
    in_valid = 1'b1;
    a4       = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_valid", {31'b0, ov_w}, 32'd0);
    check("rst_hold_r",     {28'b0, r_w},  32'd0);
    check("rst_hold_ovf",   {31'b0, ovf_w}, 32'd0);
    check("rst_hold_zero",  {31'b0, zero_w}, 32'd0);
    check("rst_hold_r16",   {16'b0, r_x},  32'd0);

    // release mid-cycle with no operand
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_valid", {31'b0, ov_w}, 32'd0);

    // consecutive directed vectors with full throughput
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].a);
      check($sformatf("v%0d_valid", i), {31'b0, ov_w},   32'd1);
      check($sformatf("v%0d_rw", i),    {28'b0, r_w},    {28'b0, vecs[i].rw});
      check($sformatf("v%0d_rs", i),    {28'b0, r_s},    {28'b0, vecs[i].rs});
      check($sformatf("v%0d_ovfw", i),  {31'b0, ovf_w},  {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_ovfs", i),  {31'b0, ovf_s},  {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_zero", i),  {31'b0, zero_w}, {31'b0, vecs[i].zero});
    end

    // operand dropped: out_valid falls, r holds -3
    step(1'b0, 4'h6);
    check("hold_valid", {31'b0, ov_w}, 32'd0);
    check("hold_r",     {28'b0, r_w},  32'hD);
    check("hold_ovf",   {31'b0, ovf_w}, 32'd0);

    // mid-stream async reset: outputs clear without a clock edge
    step(1'b1, 4'h8);
    check("pre_rst_r", {28'b0, r_s}, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, ov_w}, 32'd0);
    check("async_r",     {28'b0, r_w},  32'd0);
    check("async_ovf",   {31'b0, ovf_w}, 32'd0);
    check("async_rs",    {28'b0, r_s},  32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rel_valid", {31'b0, ov_w}, 32'd0);
    check("post_rel_r",     {28'b0, r_w},  32'd0);

    // L=16 exhaustive sweep
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      int exp_r;
      a16 = i[15:0];
      @(posedge clk);
      #1;
      exp_r = (65536 - i) % 65536;
      check("sweep_r",   {16'b0, r_x},  exp_r);
      check("sweep_ovf", {31'b0, ovf_x}, (i == 32768) ? 32'd1 : 32'd0);
      check("sweep_zero", {31'b0, zero_x}, (i == 0) ? 32'd1 : 32'd0);
      check("sweep_valid", {31'b0, ov_x}, 32'd1);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
